// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out transmitter for the shift-register link.
// Optional parity bit via PISO_PARITY_EN.
module piso_shift_tx #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] pinp,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
  localparam logic [1:0] PARITY = 2'd2;
`endif

  // Counter value while the second-to-last bit is on sout.
  localparam logic [CW-1:0] CNT_PEN = CW'(WIDTH - 2);

  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
`ifdef PISO_PARITY_EN
  logic             par;
`endif

  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] adv(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  assign load_ready = (state == IDLE);
  assign busy       = ~load_ready;

  // Frame sequencer: the state returns to IDLE while the final bit is on
  // sout, so a new word can be taken with no gap between frames.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
`ifdef PISO_PARITY_EN
      par        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (load_valid) begin
            sreg       <= adv(pinp);
            sout       <= head(pinp);
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
            state      <= SHIFT;
`ifdef PISO_PARITY_EN
            par        <= ^pinp;
`endif
          end else begin
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
          end
        end
        SHIFT: begin
          sout       <= head(sreg);
          sreg       <= adv(sreg);
          sout_valid <= 1'b1;
          if (cnt == CNT_PEN) begin
            cnt <= cnt + 1'b1;
`ifdef PISO_PARITY_EN
            sout_last <= 1'b0;
            state     <= PARITY;
`else
            sout_last <= 1'b1;
            state     <= IDLE;
`endif
          end else begin
            cnt       <= cnt + 1'b1;
            sout_last <= 1'b0;
          end
        end
`ifdef PISO_PARITY_EN
        PARITY: begin
          sout       <= par;
          sout_valid <= 1'b1;
          sout_last  <= 1'b1;
          state      <= IDLE;
        end
`endif
        default: begin
          state      <= IDLE;
          sout       <= 1'b0;
          sout_valid <= 1'b0;
          sout_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule
